// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: keyboard personality sequencer for one ps2_device byte channel.
// Queues scan-set-2 key events, answers host commands and holds LED/typematic/enable state.
module ps2_kbd_ctrl #(
   parameter int KEY_FIFO_BITS = 4,
   parameter int BAT_CYCLES    = 1000000
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   input  logic       key_ext,
   input  logic       key_brk,
   output logic [7:0] dev_wdata,
   output logic       dev_we,
   input  logic       dev_tx_empty,
   input  logic [8:0] dev_rdata,
   output logic       dev_rd,
   output logic [2:0] leds,
   output logic [6:0] typematic,
   output logic       kbd_enabled,
   output logic       overrun
);
   localparam int AW = KEY_FIFO_BITS;
   localparam logic [23:0] BAT_LOAD = 24'(BAT_CYCLES);
   typedef enum logic [2:0] {S_BAT, S_IDLE, S_RESP, S_PARAM, S_KEY} state_t;

   state_t          state_q, state_d;
   logic [9:0]      fifo_q [1<<AW];
   logic [AW:0]     wp_q, wp_d, rp_q, rp_d;
   logic [23:0]     bat_q, bat_d;
   logic [2:0][7:0] resp_q, resp_d;
   logic [1:0]      resp_n_q, resp_n_d, step_q, step_d, hold_q, hold_d;
   logic            param_q, param_d, pf3_q, pf3_d;
   logic [7:0]      last_q, last_d, wdata_q, wdata_d;
   logic            we_q, we_d, take_q, take;
   logic [2:0]      leds_q, leds_d;
   logic [6:0]      typ_q, typ_d;
   logic            en_q, en_d, ovr_q, ovr_d;
   logic            full, empty, push, pop, flush, can_tx, emit, sel_e0, sel_f0;
   logic [7:0]      tx_byte, host;
   logic [9:0]      head;

   assign empty  = wp_q == rp_q;
   assign full   = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign head   = fifo_q[rp_q[AW-1:0]];
   assign push   = key_valid && en_q && !full;
   assign take   = dev_rdata[8] && !take_q;
   assign host   = dev_rdata[7:0];
   // hold_q masks the device's stale empty flag right after a write
   assign can_tx = dev_tx_empty && !dev_rdata[8] && hold_q == 2'd0;
   assign sel_e0 = step_q == 2'd0 && head[9];
   assign sel_f0 = !sel_e0 && step_q != 2'd2 && head[8];

   always_comb begin
      state_d  = state_q;
      bat_d    = (state_q == S_BAT && bat_q != 24'd0) ? bat_q - 24'd1 : bat_q;
      resp_d   = resp_q;
      resp_n_d = resp_n_q;
      step_d   = step_q;
      hold_d   = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
      param_d  = param_q;
      pf3_d    = pf3_q;
      last_d   = last_q;
      wdata_d  = wdata_q;
      we_d     = 1'b0;
      leds_d   = leds_q;
      typ_d    = typ_q;
      en_d     = en_q;
      ovr_d    = ovr_q || (key_valid && en_q && full);
      pop      = 1'b0;
      flush    = 1'b0;
      emit     = 1'b0;
      tx_byte  = 8'h00;
      if (take) begin
         step_d   = 2'd0;
         param_d  = 1'b0;
         resp_d   = {16'h0000, 8'hFA};
         resp_n_d = 2'd1;
         state_d  = S_RESP;
         if (state_q == S_PARAM && host < 8'hED) begin
            leds_d = pf3_q ? leds_q : host[2:0];
            typ_d  = pf3_q ? host[6:0] : typ_q;
         end else begin
            case (host)
               8'hFF: begin
                  flush   = 1'b1;
                  ovr_d   = 1'b0;
                  leds_d  = 3'd0;
                  en_d    = 1'b1;
                  typ_d   = 7'h2B;
                  bat_d   = BAT_LOAD;
                  state_d = S_BAT;
               end
               8'hFE: resp_d[0] = last_q;
               8'hEE: resp_d[0] = 8'hEE;
               8'hF2: begin
                  resp_d   = {8'h83, 8'hAB, 8'hFA};
                  resp_n_d = 2'd3;
               end
               8'hF4: en_d = 1'b1;
               8'hF5: begin
                  en_d  = 1'b0;
                  flush = 1'b1;
               end
               8'hF6: begin
                  en_d  = 1'b1;
                  typ_d = 7'h2B;
               end
               8'hED, 8'hF3: begin
                  param_d = 1'b1;
                  pf3_d   = host == 8'hF3;
               end
               default: ;
            endcase
         end
      end else if (resp_n_q != 2'd0) begin
         if (can_tx) begin
            emit     = 1'b1;
            tx_byte  = resp_q[0];
            resp_d   = {8'h00, resp_q[2:1]};
            resp_n_d = resp_n_q - 2'd1;
         end
      end else begin
         case (state_q)
            S_BAT: if (bat_q == 24'd0) begin
               resp_d[0] = 8'hAA;
               resp_n_d  = 2'd1;
               state_d   = S_RESP;
            end
            S_RESP: state_d = param_q ? S_PARAM : S_IDLE;
            S_IDLE: if (!empty && en_q) state_d = S_KEY;
               else if (ovr_q && empty && can_tx) begin
                  emit  = 1'b1;
                  ovr_d = 1'b0;
               end
            S_KEY: if (can_tx) begin
               emit    = 1'b1;
               tx_byte = sel_e0 ? 8'hE0 : sel_f0 ? 8'hF0 : head[7:0];
               step_d  = sel_e0 ? 2'd1 : sel_f0 ? 2'd2 : 2'd0;
               pop     = !sel_e0 && !sel_f0;
               state_d = pop ? S_IDLE : S_KEY;
            end
            default: ;
         endcase
      end
      if (emit) begin
         we_d    = 1'b1;
         wdata_d = tx_byte;
         last_d  = tx_byte;
         hold_d  = 2'd3;
      end
      wp_d = flush ? '0 : wp_q + {{AW{1'b0}}, push};
      rp_d = flush ? '0 : rp_q + {{AW{1'b0}}, pop};
   end

   always_ff @(posedge clk_sys) begin
      if (push) fifo_q[wp_q[AW-1:0]] <= {key_ext, key_brk, key_code};
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q  <= S_BAT;
         bat_q    <= BAT_LOAD;
         wp_q     <= '0;
         rp_q     <= '0;
         resp_q   <= '0;
         resp_n_q <= 2'd0;
         step_q   <= 2'd0;
         hold_q   <= 2'd0;
         param_q  <= 1'b0;
         pf3_q    <= 1'b0;
         last_q   <= 8'h00;
         wdata_q  <= 8'h00;
         we_q     <= 1'b0;
         take_q   <= 1'b0;
         leds_q   <= 3'd0;
         typ_q    <= 7'h2B;
         en_q     <= 1'b1;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bat_q    <= bat_d;
         wp_q     <= wp_d;
         rp_q     <= rp_d;
         resp_q   <= resp_d;
         resp_n_q <= resp_n_d;
         step_q   <= step_d;
         hold_q   <= hold_d;
         param_q  <= param_d;
         pf3_q    <= pf3_d;
         last_q   <= last_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         take_q   <= take;
         leds_q   <= leds_d;
         typ_q    <= typ_d;
         en_q     <= en_d;
         ovr_q    <= ovr_d;
      end
   end

   assign dev_wdata   = wdata_q;
   assign dev_we      = we_q;
   assign dev_rd      = take_q;
   assign leds        = leds_q;
   assign typematic   = typ_q;
   assign kbd_enabled = en_q;
   assign overrun     = ovr_q;
endmodule
